// File: rtl/cache_pkg.sv
// Shared constants, line layout and FSM state encoding for the 2-way cache controller.
package cache_pkg;

   localparam int TAG_W  = 4;
   localparam int DATA_W = 5;
   localparam int SETS   = 2;
   localparam int WAYS   = 2;
   localparam int IDX_W  = $clog2(SETS);
   localparam int LINE_W = 3 + TAG_W + DATA_W;

   localparam int VALID_B  = 11;
   localparam int LRU_B    = 10;
   localparam int DIRTY_B  = 9;
   localparam int TAG_MSB  = 8;
   localparam int TAG_LSB  = 5;
   localparam int DATA_MSB = 4;
   localparam int DATA_LSB = 0;

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      COMPARE   = 3'd1,
      WRITEBACK = 3'd2,
      FILL      = 3'd3,
      DONE      = 3'd4
   } state_t;

   // Builds a valid line; the set's LRU bit is carried over unchanged by the caller.
   function automatic logic [LINE_W-1:0] make_line(
      input logic              lru,
      input logic              dirty,
      input logic [TAG_W-1:0]  tag,
      input logic [DATA_W-1:0] data
   );
      logic [LINE_W-1:0] line;
      line                    = '0;
      line[VALID_B]           = 1'b1;
      line[LRU_B]             = lru;
      line[DIRTY_B]           = dirty;
      line[TAG_MSB:TAG_LSB]   = tag;
      line[DATA_MSB:DATA_LSB] = data;
      return line;
   endfunction

endpackage

// File: rtl/cache2w_victim_sel.sv
// Victim way choice for a miss: first invalid way, else the LRU way; flags a needed write-back.
module cache2w_victim_sel
   import cache_pkg::*;
(
   input  logic [WAYS-1:0] valid,
   input  logic [WAYS-1:0] dirty,
   input  logic            lru,
   output logic            victim,
   output logic            needs_wb
);

   always_comb begin
      if (!valid[0]) begin
         victim = 1'b0;
      end else if (!valid[1]) begin
         victim = 1'b1;
      end else begin
         victim = lru;
      end
      needs_wb = valid[victim] & dirty[victim];
   end

endmodule

// File: rtl/cache2w_ctrl.sv
// Write-back, write-allocate controller for a 2-set, 2-way cache with a req/ack memory port.
module cache2w_ctrl
   import cache_pkg::*;
(
   input  logic                   clock,
   input  logic                   reset_n,
   input  logic                   cpu_req,
   input  logic                   cpu_write,
   input  logic [TAG_W-1:0]       cpu_tag,
   input  logic [IDX_W-1:0]       cpu_index,
   input  logic [DATA_W-1:0]      cpu_wdata,
   output logic                   cpu_ready,
   output logic                   cpu_hit,
   output logic [DATA_W-1:0]      cpu_rdata,
   output logic                   busy,
   output logic                   mem_rd_req,
   output logic                   mem_wr_req,
   output logic [TAG_W+IDX_W-1:0] mem_addr,
   output logic [DATA_W-1:0]      mem_wdata,
   input  logic [DATA_W-1:0]      mem_rdata,
   input  logic                   mem_ack
);

   state_t state, next_state;

   logic [LINE_W-1:0] lines [SETS][WAYS];

   logic              req_write;
   logic [TAG_W-1:0]  req_tag;
   logic [IDX_W-1:0]  req_index;
   logic [DATA_W-1:0] req_wdata;

   logic [WAYS-1:0]   set_valid;
   logic [WAYS-1:0]   set_dirty;
   logic [WAYS-1:0]   way_hit;
   logic              set_lru;
   logic              hit;
   logic              hit_way;
   logic              victim;
   logic              needs_wb;
   logic              acc_way;
   logic [LINE_W-1:0] hit_line;
   logic [LINE_W-1:0] victim_line;

   logic                   ready_d;
   logic                   hit_d;
   logic                   busy_d;
   logic                   rd_req_d;
   logic                   wr_req_d;
   logic [TAG_W+IDX_W-1:0] addr_d;
   logic [DATA_W-1:0]      wdata_d;
   logic [DATA_W-1:0]      rdata_d;

   always_comb begin
      for (int w = 0; w < WAYS; w++) begin
         set_valid[w] = lines[req_index][w][VALID_B];
         set_dirty[w] = lines[req_index][w][DIRTY_B];
         way_hit[w]   = lines[req_index][w][VALID_B] &&
                        (lines[req_index][w][TAG_MSB:TAG_LSB] == req_tag);
      end
      set_lru = lines[req_index][0][LRU_B];
      hit     = |way_hit;
      hit_way = ~way_hit[0];
   end

   assign hit_line    = lines[req_index][hit_way];
   assign victim_line = lines[req_index][victim];

   cache2w_victim_sel u_victim_sel (
      .valid    (set_valid),
      .dirty    (set_dirty),
      .lru      (set_lru),
      .victim   (victim),
      .needs_wb (needs_wb)
   );

   // Request capture: held stable for the whole transaction.
   always_ff @(posedge clock) begin
      if (state == IDLE && cpu_req) begin
         req_write <= cpu_write;
         req_tag   <= cpu_tag;
         req_index <= cpu_index;
         req_wdata <= cpu_wdata;
      end
      if (state == COMPARE) begin
         acc_way <= hit ? hit_way : victim;
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   always_comb begin
      next_state = state;
      unique case (state)
         IDLE:      if (cpu_req) next_state = COMPARE;
         COMPARE: begin
            if (hit)            next_state = DONE;
            else if (needs_wb)  next_state = WRITEBACK;
            else if (req_write) next_state = DONE;
            else                next_state = FILL;
         end
         WRITEBACK: if (mem_ack) next_state = req_write ? DONE : FILL;
         FILL:      if (mem_ack) next_state = DONE;
         DONE:      next_state = IDLE;
         default:   next_state = IDLE;
      endcase
   end

   // Output next-values; every port is a flop loaded from these.
   always_comb begin
      busy_d   = (next_state != IDLE);
      ready_d  = (state == DONE);
      rd_req_d = (next_state == FILL);
      wr_req_d = (next_state == WRITEBACK);
      hit_d    = cpu_hit;
      rdata_d  = cpu_rdata;
      addr_d   = mem_addr;
      wdata_d  = mem_wdata;
      if (state == COMPARE) begin
         hit_d = hit;
         if (hit && !req_write) rdata_d = hit_line[DATA_MSB:DATA_LSB];
      end
      if (state == FILL && mem_ack) rdata_d = mem_rdata;
      if (next_state == WRITEBACK) begin
         addr_d  = {victim_line[TAG_MSB:TAG_LSB], req_index};
         wdata_d = victim_line[DATA_MSB:DATA_LSB];
      end else if (next_state == FILL) begin
         addr_d  = {req_tag, req_index};
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         cpu_ready  <= 1'b0;
         cpu_hit    <= 1'b0;
         cpu_rdata  <= '0;
         busy       <= 1'b0;
         mem_rd_req <= 1'b0;
         mem_wr_req <= 1'b0;
         mem_addr   <= '0;
         mem_wdata  <= '0;
      end else begin
         cpu_ready  <= ready_d;
         cpu_hit    <= hit_d;
         cpu_rdata  <= rdata_d;
         busy       <= busy_d;
         mem_rd_req <= rd_req_d;
         mem_wr_req <= wr_req_d;
         mem_addr   <= addr_d;
         mem_wdata  <= wdata_d;
      end
   end

   // Line array: reset clears only the valid/lru/dirty bits; tag and data keep their contents.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         for (int s = 0; s < SETS; s++) begin
            for (int w = 0; w < WAYS; w++) begin
               lines[s][w][VALID_B] <= 1'b0;
               lines[s][w][LRU_B]   <= 1'b0;
               lines[s][w][DIRTY_B] <= 1'b0;
            end
         end
      end else begin
         unique case (state)
            COMPARE: begin
               if (hit && req_write) begin
                  lines[req_index][hit_way][DATA_MSB:DATA_LSB] <= req_wdata;
                  lines[req_index][hit_way][DIRTY_B]           <= 1'b1;
               end else if (!hit && !needs_wb && req_write) begin
                  lines[req_index][victim] <=
                     make_line(victim_line[LRU_B], 1'b1, req_tag, req_wdata);
               end
            end
            WRITEBACK: begin
               if (mem_ack) begin
                  if (req_write) begin
                     lines[req_index][acc_way] <=
                        make_line(lines[req_index][acc_way][LRU_B], 1'b1, req_tag, req_wdata);
                  end else begin
                     lines[req_index][acc_way][DIRTY_B] <= 1'b0;
                  end
               end
            end
            FILL: begin
               if (mem_ack) begin
                  lines[req_index][acc_way] <=
                     make_line(lines[req_index][acc_way][LRU_B], 1'b0, req_tag, mem_rdata);
               end
            end
            DONE: begin
               for (int w = 0; w < WAYS; w++) begin
                  lines[req_index][w][LRU_B] <= ~acc_way;
               end
            end
            default: ;
         endcase
      end
   end

endmodule
